// File: rtl/cic_pkg.sv
// Shared types and helpers for the multi-channel PDM CIC decimator.
// Imported by the integrator chain and the decimator top level.
package cic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // A PDM '1' contributes +PDM_MAG and a '0' contributes -PDM_MAG.
    localparam int PDM_MAG = 1;

    function automatic int acc_width(input int order, input int rate_w);
        return order * rate_w + 1;
    endfunction

endpackage

// File: rtl/cic_decim_mc_if.sv
// Ready/valid output stream carrying one comb result per channel slot.
interface cic_decim_mc_if #(
    parameter int ACC_W  = 33,
    parameter int CHAN_W = 1
);
    logic signed [ACC_W-1:0]  out_data;
    logic        [CHAN_W-1:0] out_chan;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output out_data,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_chan,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cic_integrator_chain.sv
// Per-channel registered integrator cascade running at the PDM strobe rate.
// Every stage wraps modulo 2^ACC_W; the comb section relies on that wrap.
module cic_integrator_chain
    import cic_pkg::*;
#(
    parameter int ORDER = 4,
    parameter int ACC_W = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    din,
    output logic signed [ACC_W-1:0] acc_last
);

    logic signed [ACC_W-1:0] integ_q [ORDER];
    logic signed [ACC_W-1:0] integ_d [ORDER];
    logic signed [ACC_W-1:0] x;

    always_comb begin
        x       = din ? ACC_W'(PDM_MAG) : ACC_W'(-PDM_MAG);
        integ_d = integ_q;
        if (en) begin
            integ_d[0] = integ_q[0] + x;
            // Each later stage adds the previous stage's value before this update.
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            integ_q <= integ_d;
        end
    end

    assign acc_last = integ_q[ORDER-1];

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: per-channel integrators, one shared comb chain
// time-multiplexed over the channels, glitch-free rate updates and overrun flag.
module cic_decim_mc
    import cic_pkg::*;
#(
    parameter int CH           = 2,
    parameter int ORDER        = 4,
    parameter int RATE_W       = 8,
    parameter int RATE_DEFAULT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              new_data,
    input  logic [CH-1:0]     din,
    input  logic [RATE_W-1:0] rate,
    input  logic              rate_we,
    output logic              overrun,
    input  logic              ovr_clr,
    cic_decim_mc_if.master    out_if
);

    localparam int ACC_W  = acc_width(ORDER, RATE_W);
    localparam int CHAN_W = (CH > 1) ? $clog2(CH) : 1;

    state_e                  state_q, state_d;
    logic [CHAN_W-1:0]       ch_idx_q, ch_idx_d;
    logic [RATE_W-1:0]       cnt_q, cnt_d;
    logic [RATE_W-1:0]       rate_q, rate_d;
    logic [RATE_W-1:0]       rate_pend_q, rate_pend_d;
    logic                    pend_q, pend_d;
    logic                    overrun_q, overrun_d;
    logic signed [ACC_W-1:0] snap_q [CH];
    logic signed [ACC_W-1:0] snap_d [CH];
    logic signed [ACC_W-1:0] dly_q [CH][ORDER];
    logic signed [ACC_W-1:0] dly_d [CH][ORDER];
    logic signed [ACC_W-1:0] stage_last [CH];
    logic signed [ACC_W-1:0] comb_y [ORDER+1];
    logic                    sample_en;
    logic                    tick;

    assign sample_en = clk_en & new_data;
    assign tick      = sample_en & (cnt_q == rate_q - 1'b1);

    for (genvar c = 0; c < CH; c++) begin : g_integ
        cic_integrator_chain #(
            .ORDER (ORDER),
            .ACC_W (ACC_W)
        ) u_chain (
            .clk      (clk),
            .rst      (rst),
            .en       (sample_en),
            .din      (din[c]),
            .acc_last (stage_last[c])
        );
    end

    always_comb begin
        comb_y[0] = snap_q[ch_idx_q];
        for (int k = 1; k <= ORDER; k++) begin
            comb_y[k] = comb_y[k-1] - dly_q[ch_idx_q][k-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        cnt_d       = cnt_q;
        rate_d      = rate_q;
        rate_pend_d = rate_pend_q;
        pend_d      = pend_q;
        overrun_d   = overrun_q;
        snap_d      = snap_q;
        dly_d       = dly_q;
        if (clk_en) begin
            if (new_data) begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            // A write landing on the tick itself stays pending for the following block.
            if (tick && pend_q) begin
                rate_d = rate_pend_q;
                pend_d = 1'b0;
            end
            if (rate_we) begin
                rate_pend_d = (rate < RATE_W'(2)) ? RATE_W'(2) : rate;
                pend_d      = 1'b1;
            end
            if (ovr_clr) begin
                overrun_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        for (int c = 0; c < CH; c++) begin
                            snap_d[c] = stage_last[c];
                        end
                        state_d  = EMIT;
                        ch_idx_d = '0;
                    end
                end
                EMIT: begin
                    if (tick) begin
                        overrun_d = 1'b1;
                    end
                    if (out_if.out_ready) begin
                        for (int k = 0; k < ORDER; k++) begin
                            dly_d[ch_idx_q][k] = comb_y[k];
                        end
                        if (ch_idx_q == CHAN_W'(CH - 1)) begin
                            state_d  = IDLE;
                            ch_idx_d = '0;
                        end else begin
                            ch_idx_d = ch_idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            cnt_q       <= '0;
            rate_q      <= RATE_W'(RATE_DEFAULT);
            rate_pend_q <= '0;
            pend_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                snap_q[c] <= '0;
                for (int k = 0; k < ORDER; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            cnt_q       <= cnt_d;
            rate_q      <= rate_d;
            rate_pend_q <= rate_pend_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            snap_q      <= snap_d;
            dly_q       <= dly_d;
        end
    end

    assign out_if.out_valid = (state_q == EMIT);
    assign out_if.out_chan  = ch_idx_q;
    assign out_if.out_data  = (state_q == EMIT) ? comb_y[ORDER] : '0;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench for cic_decim_mc at CH=2, ORDER=4, RATE_W=8 with hand-derived
// steady-state values (rate^ORDER) and block timing in PDM-sample counts.
module tb_cic_decim_mc;
    import cic_pkg::*;

    localparam int CH     = 2;
    localparam int ORDER  = 4;
    localparam int RATE_W = 8;
    localparam int ACC_W  = acc_width(ORDER, RATE_W);
    localparam int CHAN_W = 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t DC8  = 4096;
    localparam acc_t DC16 = 65536;
    localparam acc_t DC2  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b1;
    logic              new_data = 1'b0;
    logic [CH-1:0]     din = '0;
    logic [RATE_W-1:0] rate = '0;
    logic              rate_we = 1'b0;
    logic              ovr_clr = 1'b0;
    logic              overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int stamp    = 0;

    acc_t              cap_data[$];
    logic [CHAN_W-1:0] cap_chan[$];
    int                cap_stamp[$];

    cic_decim_mc_if #(.ACC_W(ACC_W), .CHAN_W(CHAN_W)) out_if ();

    cic_decim_mc #(
        .CH           (CH),
        .ORDER        (ORDER),
        .RATE_W       (RATE_W),
        .RATE_DEFAULT (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .new_data (new_data),
        .din      (din),
        .rate     (rate),
        .rate_we  (rate_we),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .out_if   (out_if)
    );

    always #5 clk = ~clk;

    // Record every accepted transfer with the number of samples sent so far.
    always @(negedge clk) begin
        if (rst && clk_en && out_if.out_valid && out_if.out_ready) begin
            cap_data.push_back(out_if.out_data);
            cap_chan.push_back(out_if.out_chan);
            cap_stamp.push_back(stamp);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; clk_en = 1'b1; new_data = 1'b0; din = '0;
        rate_we = 1'b0; ovr_clr = 1'b0; out_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cap_data.delete(); cap_chan.delete(); cap_stamp.delete();
        stamp = 0;
    endtask

    task automatic send_sample(input logic [CH-1:0] bits);
        @(posedge clk); #1;
        new_data = 1'b1; din = bits; stamp++;
        @(posedge clk); #1;
        new_data = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic write_rate(input logic [RATE_W-1:0] v);
        @(posedge clk); #1;
        rate_we = 1'b1; rate = v;
        @(posedge clk); #1;
        rate_we = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        n_checks++;
        if (out_if.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_if.out_valid);
        else n_pass++;
        n_checks++;
        if (out_if.out_data !== acc_t'(0)) $display("[TB] FAIL reset_data: got %0d expected 0", out_if.out_data);
        else n_pass++;
        n_checks++;
        if (out_if.out_chan !== 1'b0) $display("[TB] FAIL reset_chan: got %0d expected 0", out_if.out_chan);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_dc();
        acc_t e;
        do_reset();
        for (int i = 0; i < 80; i++) send_sample(2'b01);
        n_checks++;
        if (cap_data.size() != 20) $display("[TB] FAIL dc_count: got %0d expected 20", cap_data.size());
        else n_pass++;
        n_checks++;
        if (cap_stamp.size() == 0 || cap_stamp[0] != 8) $display("[TB] FAIL dc_first_block: got stamp %0d expected 8", cap_stamp.size() == 0 ? -1 : cap_stamp[0]);
        else n_pass++;
        for (int i = 10; i < cap_data.size(); i++) begin
            e = (i % 2 == 0) ? DC8 : -DC8;
            n_checks++;
            if (cap_chan[i] !== CHAN_W'(i % 2)) $display("[TB] FAIL dc_chan[%0d]: got %0d expected %0d", i, cap_chan[i], i % 2);
            else n_pass++;
            n_checks++;
            if (cap_data[i] !== e) $display("[TB] FAIL dc_data[%0d]: got %0d expected %0d", i, cap_data[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int i = 0; i < 80; i++) send_sample((i % 2 == 0) ? 2'b11 : 2'b00);
        n_checks++;
        if (cap_data.size() != 20) $display("[TB] FAIL alt_count: got %0d expected 20", cap_data.size());
        else n_pass++;
        for (int i = 10; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== acc_t'(0)) $display("[TB] FAIL alt_data[%0d]: got %0d expected 0", i, cap_data[i]);
            else n_pass++;
        end
        n_checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL alt_overrun: got %b expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_rate_change();
        acc_t e;
        do_reset();
        for (int i = 0; i < 12; i++) send_sample(2'b01);
        write_rate(8'd16);
        for (int i = 0; i < 128; i++) send_sample(2'b01);
        n_checks++;
        if (cap_data.size() != 18) $display("[TB] FAIL rate16_count: got %0d expected 18", cap_data.size());
        else n_pass++;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (cap_stamp.size() <= 2 * b || cap_stamp[2*b] != ((b == 0) ? 8 : 16 * b))
                $display("[TB] FAIL rate16_stamp[%0d]: got %0d expected %0d", b, cap_stamp.size() <= 2 * b ? -1 : cap_stamp[2*b], (b == 0) ? 8 : 16 * b);
            else n_pass++;
        end
        for (int i = 12; i < cap_data.size(); i++) begin
            e = (i % 2 == 0) ? DC16 : -DC16;
            n_checks++;
            if (cap_data[i] !== e) $display("[TB] FAIL rate16_data[%0d]: got %0d expected %0d", i, cap_data[i], e);
            else n_pass++;
        end

        do_reset();
        write_rate(8'd1);
        for (int i = 0; i < 48; i++) send_sample(2'b01);
        n_checks++;
        if (cap_data.size() != 42) $display("[TB] FAIL rate2_count: got %0d expected 42", cap_data.size());
        else n_pass++;
        n_checks++;
        if (cap_stamp.size() < 3 || cap_stamp[2] != 10) $display("[TB] FAIL rate2_stamp: got %0d expected 10", cap_stamp.size() < 3 ? -1 : cap_stamp[2]);
        else n_pass++;
        for (int i = 32; i < cap_data.size(); i++) begin
            e = (i % 2 == 0) ? DC2 : -DC2;
            n_checks++;
            if (cap_data[i] !== e) $display("[TB] FAIL rate2_data[%0d]: got %0d expected %0d", i, cap_data[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        for (int i = 0; i < 64; i++) send_sample(2'b01);
        out_if.out_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) send_sample(2'b01);
            @(negedge clk);
            n_checks++;
            if (out_if.out_valid !== 1'b1 || out_if.out_chan !== 1'b0 || out_if.out_data !== DC8)
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b chan=%0d data=%0d expected valid=1 chan=0 data=%0d",
                         p, out_if.out_valid, out_if.out_chan, out_if.out_data, DC8);
            else n_pass++;
        end
        n_checks++;
        if (overrun !== 1'b1) $display("[TB] FAIL bp_overrun_set: got %b expected 1", overrun);
        else n_pass++;
        n0 = cap_data.size();
        @(posedge clk); #1;
        out_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cap_data.size() != n0 + 2) $display("[TB] FAIL bp_release_count: got %0d expected %0d", cap_data.size(), n0 + 2);
        else n_pass++;
        n_checks++;
        if (cap_chan[n0] !== 1'b0 || cap_data[n0] !== DC8) $display("[TB] FAIL bp_release_ch0: got chan=%0d data=%0d expected chan=0 data=%0d", cap_chan[n0], cap_data[n0], DC8);
        else n_pass++;
        n_checks++;
        if (cap_chan[n0+1] !== 1'b1 || cap_data[n0+1] !== -DC8) $display("[TB] FAIL bp_release_ch1: got chan=%0d data=%0d expected chan=1 data=%0d", cap_chan[n0+1], cap_data[n0+1], -DC8);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("[TB] FAIL bp_overrun_sticky: got %b expected 1", overrun);
        else n_pass++;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL bp_overrun_clear: got %b expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_clk_en();
        int n0;
        do_reset();
        for (int i = 0; i < 64; i++) send_sample(2'b01);
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_sample(2'b01);
        n0 = cap_data.size();
        clk_en = 1'b0;
        out_if.out_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            new_data = 1'b1; din = 2'b01;
            @(posedge clk); #1;
            new_data = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_if.out_valid !== 1'b1 || out_if.out_chan !== 1'b0 || out_if.out_data !== DC8 || overrun !== 1'b0)
                $display("[TB] FAIL en_freeze[%0d]: got valid=%b chan=%0d data=%0d ovr=%b expected valid=1 chan=0 data=%0d ovr=0",
                         p, out_if.out_valid, out_if.out_chan, out_if.out_data, overrun, DC8);
            else n_pass++;
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_sample(2'b01);
        n_checks++;
        if (cap_data.size() != n0 + 4) $display("[TB] FAIL en_count: got %0d expected %0d", cap_data.size(), n0 + 4);
        else n_pass++;
        for (int i = n0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== ((i % 2 == 0) ? DC8 : -DC8) || cap_stamp[i] != ((i < n0 + 2) ? 72 : 80))
                $display("[TB] FAIL en_after[%0d]: got data=%0d stamp=%0d expected data=%0d stamp=%0d",
                         i, cap_data[i], cap_stamp[i], (i % 2 == 0) ? DC8 : -DC8, (i < n0 + 2) ? 72 : 80);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 64; i++) send_sample(2'b01);
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_sample(2'b01);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_if.out_valid !== 1'b0 || out_if.out_data !== acc_t'(0))
            $display("[TB] FAIL areset_immediate: got valid=%b data=%0d expected valid=0 data=0", out_if.out_valid, out_if.out_data);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_if.out_ready = 1'b1;
        cap_data.delete(); cap_chan.delete(); cap_stamp.delete();
        stamp = 0;
        for (int i = 0; i < 80; i++) send_sample(2'b01);
        n_checks++;
        if (cap_stamp.size() == 0 || cap_stamp[0] != 8) $display("[TB] FAIL areset_first_block: got stamp %0d expected 8", cap_stamp.size() == 0 ? -1 : cap_stamp[0]);
        else n_pass++;
        for (int i = 10; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== ((i % 2 == 0) ? DC8 : -DC8))
                $display("[TB] FAIL areset_data[%0d]: got %0d expected %0d", i, cap_data[i], (i % 2 == 0) ? DC8 : -DC8);
            else n_pass++;
        end
    endtask

    initial begin
        out_if.out_ready = 1'b1;
        test_reset();
        test_dc();
        test_alternating();
        test_rate_change();
        test_backpressure();
        test_clk_en();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
